// File: rtl/cpu_pio_pkg.sv
// Shared constants for the cpu_pio_out register block.
package cpu_pio_pkg;

    localparam int unsigned ADDR_W = 3;
    localparam int unsigned BUS_W  = 32;

    localparam logic [ADDR_W-1:0] ADDR_DATA       = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_SET        = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_CLEAR      = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_TOGGLE     = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_BLINK_MASK = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_PERIOD     = 3'd5;
    localparam logic [ADDR_W-1:0] ADDR_PHASE      = 3'd6;

    localparam logic [BUS_W-1:0] READ_ZERO = 32'h0000_0000;

endpackage

// File: rtl/cpu_pio_blink_timer.sv
// Blink half-period counter and phase bit. The phase flips every period+1
// cycles; period==0 parks the timer, and a period write restarts it.
module cpu_pio_blink_timer #(
    parameter int unsigned PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PERIOD_W-1:0] period,
    input  logic                period_wr,
    output logic                phase,
    output logic                phase_next_c
);

    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic                phase_q, phase_d;

    // Next count/phase; a period write overrides counting and toggling.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (period_wr) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (period == '0) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == period) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + PERIOD_W'(1);
        end
    end

    // Timer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase        = phase_q;
    assign phase_next_c = phase_d;

endmodule

// File: rtl/cpu_pio_out.sv
// Avalon-MM parallel output port with SET/CLEAR/TOGGLE aliases.
// Optional per-channel blinking is built in when CPU_PIO_OUT_BLINK_EN is defined.
module cpu_pio_out
    import cpu_pio_pkg::*;
#(
    parameter int unsigned     WIDTH       = 3,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int unsigned     PERIOD_W    = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [BUS_W-1:0]  writedata,
    output logic [BUS_W-1:0]  readdata,
    output logic [WIDTH-1:0]  out_port
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("cpu_pio_out: WIDTH out of range 1..32");
    end
    if (PERIOD_W < 1 || PERIOD_W > 32) begin : g_bad_period_w
        $error("cpu_pio_out: PERIOD_W out of range 1..32");
    end

    logic             wr_c;
    logic [WIDTH-1:0] wd_c;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] out_port_q, out_port_d;
    logic             unused_writedata_c;

    assign wr_c               = chipselect & ~write_n;
    assign wd_c               = writedata[WIDTH-1:0];
    assign unused_writedata_c = ^writedata;

    // DATA next value from direct write or bit-wise alias writes.
    always_comb begin
        data_d = data_q;
        if (wr_c) begin
            case (address)
                ADDR_DATA:   data_d = wd_c;
                ADDR_SET:    data_d = data_q | wd_c;
                ADDR_CLEAR:  data_d = data_q & ~wd_c;
                ADDR_TOGGLE: data_d = data_q ^ wd_c;
                default:     data_d = data_q;
            endcase
        end
    end

`ifdef CPU_PIO_OUT_BLINK_EN
    logic [WIDTH-1:0]    mask_q, mask_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                period_wr_c;
    logic                phase_q;
    logic                phase_next_c;

    // BLINK_MASK and PERIOD register writes.
    always_comb begin
        mask_d      = mask_q;
        period_d    = period_q;
        period_wr_c = 1'b0;
        if (wr_c && address == ADDR_BLINK_MASK) begin
            mask_d = wd_c;
        end
        if (wr_c && address == ADDR_PERIOD) begin
            period_d    = writedata[PERIOD_W-1:0];
            period_wr_c = 1'b1;
        end
    end

    cpu_pio_blink_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_blink_timer (
        .clk          (clk),
        .reset        (reset),
        .period       (period_q),
        .period_wr    (period_wr_c),
        .phase        (phase_q),
        .phase_next_c (phase_next_c)
    );

    // Output uses next-state values so it lines up with the register contents.
    always_comb begin
        out_port_d = data_d & ~(mask_d & {WIDTH{phase_next_c}});
    end

    // Blink configuration registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q   <= '0;
            period_q <= '0;
        end else begin
            mask_q   <= mask_d;
            period_q <= period_d;
        end
    end
`else
    // Without blinking the output simply mirrors DATA.
    always_comb begin
        out_port_d = data_d;
    end
`endif

    // DATA and output registers; reset wins over a same-cycle write.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q     <= RESET_VALUE;
            out_port_q <= RESET_VALUE;
        end else begin
            data_q     <= data_d;
            out_port_q <= out_port_d;
        end
    end

    // Zero-wait-state read mux; write-only and reserved addresses read zero.
    always_comb begin
        readdata = READ_ZERO;
        case (address)
            ADDR_DATA:       readdata = BUS_W'(data_q);
`ifdef CPU_PIO_OUT_BLINK_EN
            ADDR_BLINK_MASK: readdata = BUS_W'(mask_q);
            ADDR_PERIOD:     readdata = BUS_W'(period_q);
            ADDR_PHASE:      readdata = BUS_W'(phase_q);
`endif
            default:         readdata = READ_ZERO;
        endcase
    end

    assign out_port = out_port_q;

endmodule

// File: tb/tb_cpu_pio_out.sv
// Directed self-checking bench for cpu_pio_out (WIDTH=3, RESET_VALUE=3'b101).
// Blink scenarios are exercised when CPU_PIO_OUT_BLINK_EN is defined.
module tb_cpu_pio_out;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [2:0]  out_port;

    int unsigned errors = 0;
    int unsigned checks = 0;

    cpu_pio_out #(
        .WIDTH       (3),
        .RESET_VALUE (3'b101),
        .PERIOD_W    (24)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
        address = a;
        #1;
        chk(tag, readdata, exp);
    endtask

    initial begin
        reset      = 1'b1;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;

        // Reset state
        chk("reset_out", 32'(out_port), 32'h5);
        rd_chk("reset_rd_data", 3'd0, 32'h5);
        rd_chk("reset_rd_mask", 3'd4, 32'h0);

        // DATA write uses only the low WIDTH bits
        bus_write(3'd0, 32'hFFFF_FFFA);
        chk("data_out", 32'(out_port), 32'h2);
        rd_chk("data_rd", 3'd0, 32'h2);

        // SET / CLEAR / TOGGLE aliases
        bus_write(3'd0, 32'h0);
        bus_write(3'd1, 32'h5);
        chk("set_out", 32'(out_port), 32'h5);
        rd_chk("set_rd", 3'd1, 32'h0);
        bus_write(3'd2, 32'h4);
        chk("clear_out", 32'(out_port), 32'h1);
        rd_chk("clear_rd", 3'd2, 32'h0);
        bus_write(3'd3, 32'h7);
        chk("toggle_out", 32'(out_port), 32'h6);
        rd_chk("toggle_rd", 3'd3, 32'h0);
        rd_chk("reserved_rd", 3'd7, 32'h0);

        // Write strobe without chipselect, and writes to RO/reserved, are ignored
        @(negedge clk);
        address = 3'd0; writedata = 32'h1; chipselect = 1'b0; write_n = 1'b0;
        step();
        write_n = 1'b1;
        chk("no_cs_out", 32'(out_port), 32'h6);
        bus_write(3'd6, 32'h1);
        bus_write(3'd7, 32'h1);
        rd_chk("ro_write_data", 3'd0, 32'h6);
        rd_chk("ro_write_phase", 3'd6, 32'h0);

`ifdef CPU_PIO_OUT_BLINK_EN
        // Blink: DATA=7, mask=2, PERIOD=3 -> 4 cycles of 7, 4 cycles of 5
        bus_write(3'd0, 32'h7);
        bus_write(3'd4, 32'h2);
        rd_chk("mask_rd", 3'd4, 32'h2);
        bus_write(3'd5, 32'h3);
        rd_chk("period_rd", 3'd5, 32'h3);
        address = 3'd6;
        for (int i = 0; i < 12; i++) begin
            if (i != 0) step();
            chk($sformatf("blink_out_%0d", i), 32'(out_port), (((i / 4) % 2) == 1) ? 32'h5 : 32'h7);
            chk($sformatf("blink_phase_%0d", i), readdata, 32'((i / 4) % 2));
        end
        step();
        chk("pre_rewrite_phase", readdata, 32'h1);
        chk("pre_rewrite_out", 32'(out_port), 32'h5);

        // PERIOD rewrite mid-count restarts the timer from phase 0
        bus_write(3'd5, 32'h3);
        address = 3'd6;
        #1;
        chk("rewrite_phase", readdata, 32'h0);
        chk("rewrite_out", 32'(out_port), 32'h7);
        repeat (3) step();
        chk("rewrite_hold_out", 32'(out_port), 32'h7);
        step();
        chk("rewrite_flip_out", 32'(out_port), 32'h5);

        // PERIOD=0 parks the timer: steady DATA
        bus_write(3'd5, 32'h0);
        address = 3'd6;
        for (int i = 0; i < 6; i++) begin
            if (i != 0) step();
            chk($sformatf("period0_out_%0d", i), 32'(out_port), 32'h7);
            chk($sformatf("period0_phase_%0d", i), readdata, 32'h0);
        end

        // Get into phase 1 with PERIOD=1 before the reset test
        bus_write(3'd5, 32'h1);
        repeat (2) step();
        chk("preset_out", 32'(out_port), 32'h5);
`else
        // Blink registers absent: reads zero, writes ignored, no toggling
        bus_write(3'd0, 32'h7);
        bus_write(3'd4, 32'h7);
        bus_write(3'd5, 32'h1);
        rd_chk("noblink_rd4", 3'd4, 32'h0);
        rd_chk("noblink_rd5", 3'd5, 32'h0);
        rd_chk("noblink_rd6", 3'd6, 32'h0);
        for (int i = 0; i < 6; i++) begin
            if (i != 0) step();
            chk($sformatf("noblink_out_%0d", i), 32'(out_port), 32'h7);
        end
`endif

        // Reset with a same-cycle DATA write: write is lost
        @(negedge clk);
        reset      = 1'b1;
        address    = 3'd0;
        writedata  = 32'h0;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step();
        chipselect = 1'b0;
        write_n    = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_wr_out", 32'(out_port), 32'h5);
        rd_chk("rst_wr_data", 3'd0, 32'h5);
        rd_chk("rst_wr_phase", 3'd6, 32'h0);
        step();
        chk("rst_wr_out_hold", 32'(out_port), 32'h5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_pio_out.md
CPU_PIO_OUT -- requirements
Module: cpu_pio_out

Interface
REQ-001 The block SHALL have parameter WIDTH, default 3: number of output channels, legal range 1..32.
REQ-002 The block SHALL have parameter RESET_VALUE, default 0: WIDTH-bit DATA value loaded on reset.
REQ-003 The block SHALL have parameter PERIOD_W, default 24: width of the blink half-period register, legal range 1..32.
REQ-004 Port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port address, input, 3 bits: Avalon-MM word address.
REQ-007 Port chipselect, input, 1 bit: slave select.
REQ-008 Port write_n, input, 1 bit: active-low write strobe.
REQ-009 Port writedata, input, 32 bits: write data.
REQ-010 Port readdata, output, 32 bits: read data, combinational from address, zero wait states.
REQ-011 Port out_port, output, WIDTH bits: registered channel outputs.

Function
REQ-012 A write SHALL occur in a cycle where chipselect=1 and write_n=0; only writedata[WIDTH-1:0] is used, and upper bits are ignored.
REQ-013 Register map:
- 0 DATA: R/W.
- 1 SET: W; DATA |= wd.
- 2 CLEAR: W; DATA &= ~wd.
- 3 TOGGLE: W; DATA ^= wd.
- 4 BLINK_MASK: R/W, WIDTH bits.
- 5 PERIOD: R/W, PERIOD_W bits.
- 6 PHASE: RO, bit0 = blink phase.
- 7: reserved.
REQ-014 readdata SHALL be zero-extended register contents; SET, CLEAR, TOGGLE and reserved addresses SHALL read 0.
REQ-015 Reads SHALL have no side effects, and writes to RO or reserved addresses SHALL be ignored.
REQ-016 Written values SHALL be visible on readdata and out_port in the cycle after the write edge (1-cycle latency).
REQ-017 The blink timer SHALL hold a PERIOD_W-bit counter cnt and a phase bit.
- When PERIOD=0: cnt=0 and phase=0, held.
- Otherwise cnt increments each cycle; when cnt==PERIOD, cnt wraps to 0 and phase toggles.
- Result: phase period is 2*(PERIOD+1) cycles.
REQ-018 A write to PERIOD SHALL also clear cnt and phase in the same edge; this write takes priority over the count and toggle.
REQ-019 out_port SHALL be registered as DATA & ~(BLINK_MASK & {WIDTH{phase}}), computed from the next-state values so that REQ-016 holds.
REQ-020 Writes to DATA, SET, CLEAR or TOGGLE SHALL NOT disturb cnt or phase.
REQ-021 At PERIOD at its maximum (all ones), cnt SHALL wrap without overflow error.

Reset
REQ-022 While reset=1 at a clock edge, the block SHALL load DATA=RESET_VALUE, BLINK_MASK=0, PERIOD=0, cnt=0, phase=0 and out_port=RESET_VALUE.
REQ-023 Reset SHALL take priority over a simultaneous write, which is lost.
REQ-024 Reset asserted mid-blink SHALL return phase to 0 on that edge.

Configuration
REQ-025 With macro CPU_PIO_OUT_BLINK_EN defined, the block SHALL include BLINK_MASK, PERIOD, PHASE, cnt and phase as specified above.
REQ-026 Without CPU_PIO_OUT_BLINK_EN:
- addresses 4-6 SHALL read 0 and ignore writes;
- no timer logic SHALL exist;
- out_port SHALL equal DATA.

Structure
REQ-027 Package cpu_pio_pkg SHALL hold the address constants (ADDR_DATA..ADDR_PHASE) and the read-zero constant.
REQ-028 The counter and phase logic SHALL be sub-module cpu_pio_blink_timer, with ports clk, reset, period, period_wr and phase, and it SHALL be instantiated only under CPU_PIO_OUT_BLINK_EN.

Verification
REQ-029 Reset and DATA write: with WIDTH=3 and RESET_VALUE=3'b101, reset -> out_port=5; write DATA=0xFFFF_FFFA -> next cycle out_port=3'b010 and readdata@0=0x2.
REQ-030 SET, CLEAR and TOGGLE: from DATA=0, SET 0x5 -> 5; CLEAR 0x4 -> 1; TOGGLE 0x7 -> 6; readdata@1..3 = 0 throughout.
REQ-031 Blink: DATA=7, BLINK_MASK=2, PERIOD=3 -> out_port alternates 7 and 5 every 4 cycles; PHASE readback matches.
REQ-032 PERIOD rewrite mid-count: write PERIOD=3 while phase=1 -> phase=0 and cnt restarts at 0 on the next cycle; writing PERIOD=0 -> out_port=DATA steady.
REQ-033 Reset mid-blink combined with a same-cycle DATA write -> write discarded, out_port=RESET_VALUE, PHASE=0.
REQ-034 Build without CPU_PIO_OUT_BLINK_EN: write BLINK_MASK=7 and PERIOD=1 -> readdata@4..6=0, and out_port tracks DATA with no toggling.
